// File: rtl/ps2_key_pkg.sv
// Shared types and constants for the ps2_key event decoder.
// Pause handling in the decoder depends on the PS2_PAUSE_EN macro.
package ps2_key_pkg;

    // One normalised key event as it sits in the event FIFO.
    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       pressed;
    } ps2_evt_t;

    localparam logic [7:0] PS2_EXT        = 8'hE0;
    localparam logic [7:0] PS2_BRK        = 8'hF0;
    localparam logic [7:0] PS2_PAUSE      = 8'hE1;
    localparam logic [7:0] PS2_PAUSE_CODE = 8'h77;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } ps2_state_e;

    // Byte values that can never be the final scan code of an event.
    function automatic logic is_reserved(input logic [7:0] b);
        return (b == 8'h00) || (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Event read-out bundle between the decoder (master) and the keyboard-matrix logic (slave).
interface ps2_key_decoder_if #(
    parameter int FIFO_BITS = 4
);
    logic                 ev_valid;
    logic [7:0]           ev_code;
    logic                 ev_ext;
    logic                 ev_pressed;
    logic                 ev_rd;
    logic [FIFO_BITS:0]   ev_count;
    logic                 ev_ovf;
    logic                 ovf_clr;

    modport master (
        output ev_valid, ev_code, ev_ext, ev_pressed, ev_count, ev_ovf,
        input  ev_rd, ovf_clr
    );

    modport slave (
        input  ev_valid, ev_code, ev_ext, ev_pressed, ev_count, ev_ovf,
        output ev_rd, ovf_clr
    );
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO of key events; a push into a full FIFO is dropped
// unless a pop happens in the same cycle.
module ps2_evt_fifo
    import ps2_key_pkg::*;
#(
    parameter int FIFO_BITS = 4
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               push,
    input  ps2_evt_t           push_evt,
    input  logic               pop,
    output ps2_evt_t           head_evt,
    output logic               empty,
    output logic               full,
    output logic [FIFO_BITS:0] count
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam logic [FIFO_BITS:0] FULL_COUNT = {1'b1, {FIFO_BITS{1'b0}}};

    ps2_evt_t             mem [DEPTH];
    logic [FIFO_BITS-1:0] wr_ptr;
    logic [FIFO_BITS-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign push_ok  = push && (!full || pop);
    assign pop_ok   = pop && !empty;
    assign head_evt = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally; count tracks the occupancy including the full state.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Event storage; left unreset because the head is masked while empty.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_evt;
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns each toggle of the hps_io ps2_key word into one key event
// and queues it for the core. Define PS2_PAUSE_EN to report Pause (E1 sequence)
// as a single make of E0 77; without it, Pause words are discarded.
module ps2_key_decoder
    import ps2_key_pkg::*;
#(
    parameter int FIFO_BITS = 4
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [64:0] ps2_key,
    ps2_key_decoder_if.master evt
);
    ps2_state_e         state;
    ps2_state_e         state_nxt;
    logic               prev_tgl;
    logic               toggle;
    logic [63:0]        work_word;
    logic [63:0]        pend_word;
    logic               pend_full;
    logic [2:0]         byte_idx;
    logic [7:0]         scan_byte;
    logic               flag_ext;
    logic               flag_brk;
    logic               flag_pause;
    logic               start_scan;
    logic               cap_drop;
    logic               emit_push;
    ps2_evt_t           emit_evt;
    ps2_evt_t           head_evt;
    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_drop;
    logic [FIFO_BITS:0] fifo_count;

    assign toggle     = ps2_key[64] ^ prev_tgl;
    assign scan_byte  = work_word[{byte_idx, 3'b000} +: 8];
    assign start_scan = (state == IDLE) && (state_nxt == SCAN);
    assign cap_drop   = toggle && (state != IDLE) && pend_full;
    assign fifo_drop  = emit_push && fifo_full && !evt.ev_rd;

    // Toggle reference and FSM state; reset re-syncs the reference so it never fires.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            prev_tgl <= ps2_key[64];
            state    <= IDLE;
        end else begin
            prev_tgl <= ps2_key[64];
            state    <= state_nxt;
        end
    end

    // Capture: idle engine takes the word directly, busy engine parks it in pending.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            work_word <= '0;
            pend_word <= '0;
            pend_full <= 1'b0;
        end else if (state == IDLE) begin
            if (pend_full) begin
                work_word <= pend_word;
                pend_full <= toggle;
                if (toggle) begin
                    pend_word <= ps2_key[63:0];
                end
            end else if (toggle) begin
                work_word <= ps2_key[63:0];
            end
        end else if (toggle && !pend_full) begin
            pend_word <= ps2_key[63:0];
            pend_full <= 1'b1;
        end
    end

    // Walk prefix bytes 7..1 of the work word, collecting the modifier flags.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            byte_idx   <= 3'd7;
            flag_ext   <= 1'b0;
            flag_brk   <= 1'b0;
            flag_pause <= 1'b0;
        end else if (start_scan) begin
            byte_idx   <= 3'd7;
            flag_ext   <= 1'b0;
            flag_brk   <= 1'b0;
            flag_pause <= 1'b0;
        end else if (state == SCAN) begin
            byte_idx <= byte_idx - 3'd1;
            case (scan_byte)
                PS2_EXT:   flag_ext   <= 1'b1;
                PS2_BRK:   flag_brk   <= 1'b1;
                PS2_PAUSE: flag_pause <= 1'b1;
                default:   ;
            endcase
        end
    end

    // Next-state logic: pending work has priority, scan runs seven bytes, emit lasts one cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend_full || toggle) state_nxt = SCAN;
            SCAN:    if (byte_idx == 3'd1) state_nxt = EMIT;
            EMIT:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Build the event in EMIT from byte 0 and the flags; reserved codes never reach the FIFO.
    always_comb begin
        emit_push = 1'b0;
        emit_evt  = '0;
        if (state == EMIT) begin
`ifdef PS2_PAUSE_EN
            if (flag_pause) begin
                emit_push        = 1'b1;
                emit_evt.code    = PS2_PAUSE_CODE;
                emit_evt.ext     = 1'b1;
                emit_evt.pressed = 1'b1;
            end else if (!is_reserved(work_word[7:0])) begin
                emit_push        = 1'b1;
                emit_evt.code    = work_word[7:0];
                emit_evt.ext     = flag_ext;
                emit_evt.pressed = ~flag_brk;
            end
`else
            if (!flag_pause && !is_reserved(work_word[7:0])) begin
                emit_push        = 1'b1;
                emit_evt.code    = work_word[7:0];
                emit_evt.ext     = flag_ext;
                emit_evt.pressed = ~flag_brk;
            end
`endif
        end
    end

    ps2_evt_fifo #(
        .FIFO_BITS (FIFO_BITS)
    ) u_fifo (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .push     (emit_push),
        .push_evt (emit_evt),
        .pop      (evt.ev_rd),
        .head_evt (head_evt),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign evt.ev_valid   = ~fifo_empty;
    assign evt.ev_code    = head_evt.code;
    assign evt.ev_ext     = head_evt.ext;
    assign evt.ev_pressed = head_evt.pressed;
    assign evt.ev_count   = fifo_count;

    // Sticky overflow: any lost capture or event sets it, and setting beats clearing.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            evt.ev_ovf <= 1'b0;
        end else if (cap_drop || fifo_drop) begin
            evt.ev_ovf <= 1'b1;
        end else if (evt.ovf_clr) begin
            evt.ev_ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios with literal
// expectations plus a randomized phase, all compared every cycle against an
// event-level reference model. Honours PS2_PAUSE_EN like the design.
module tb_ps2_key_decoder;

    localparam int FB    = 4;
    localparam int DEPTH = 1 << FB;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic [64:0] ps2_key;

    int checks = 0;
    int errors = 0;

    ps2_key_decoder_if #(.FIFO_BITS(FB)) evt_if ();

    ps2_key_decoder #(.FIFO_BITS(FB)) dut (
        .clk_sys (clk_sys),
        .reset   (reset),
        .ps2_key (ps2_key),
        .evt     (evt_if)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    logic [9:0]  mq[$];
    logic        m_ovf;
    logic        m_prev;
    logic        pend_v;
    logic [63:0] pend_w;
    logic        sched_v;
    longint      sched_at;
    logic [10:0] sched_evt;
    longint      busy_end;
    longint      cyc = 0;
    bit          model_live = 0;

    // Decode a whole word into {push, code, ext, pressed} straight from the rules.
    function automatic logic [10:0] decode(input logic [63:0] w);
        logic ext = 1'b0;
        logic brk = 1'b0;
        logic pause = 1'b0;
        logic [7:0] b;
        logic [7:0] code;
        for (int i = 7; i >= 1; i--) begin
            b = w[8*i +: 8];
            if (b == 8'hE0) ext = 1'b1;
            if (b == 8'hF0) brk = 1'b1;
            if (b == 8'hE1) pause = 1'b1;
        end
        code = w[7:0];
`ifdef PS2_PAUSE_EN
        if (pause) return {1'b1, 8'h77, 1'b1, 1'b1};
`endif
        if (pause || code == 8'h00 || code == 8'hE0 || code == 8'hF0 || code == 8'hE1)
            return '0;
        return {1'b1, code, ext, ~brk};
    endfunction

    // Word accepted by the idle engine: its event lands in the FIFO eight edges later.
    task automatic startWord(input logic [63:0] w);
        busy_end  = cyc + 8;
        sched_v   = 1'b1;
        sched_at  = cyc + 8;
        sched_evt = decode(w);
    endtask

    always @(posedge clk_sys) begin : model_step
        logic tgl;
        logic cap_drop;
        logic fifo_drop;
        logic have_push;
        logic [9:0] push_val;
        logic do_pop;
        cyc++;
        if (reset) begin
            mq.delete();
            m_ovf      = 1'b0;
            pend_v     = 1'b0;
            sched_v    = 1'b0;
            busy_end   = cyc;
            m_prev     = ps2_key[64];
            model_live = 1;
        end else begin
            tgl       = (ps2_key[64] != m_prev);
            m_prev    = ps2_key[64];
            cap_drop  = 1'b0;
            fifo_drop = 1'b0;
            have_push = 1'b0;
            push_val  = '0;
            if (sched_v && sched_at == cyc) begin
                sched_v   = 1'b0;
                have_push = sched_evt[10];
                push_val  = sched_evt[9:0];
            end
            if (cyc > busy_end) begin
                if (pend_v) begin
                    startWord(pend_w);
                    pend_v = tgl;
                    if (tgl) pend_w = ps2_key[63:0];
                end else if (tgl) begin
                    startWord(ps2_key[63:0]);
                end
            end else if (tgl) begin
                if (!pend_v) begin
                    pend_v = 1'b1;
                    pend_w = ps2_key[63:0];
                end else begin
                    cap_drop = 1'b1;
                end
            end
            do_pop = evt_if.ev_rd && (mq.size() > 0);
            if (have_push && mq.size() == DEPTH && !do_pop) fifo_drop = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (have_push && !fifo_drop) mq.push_back(push_val);
            if (cap_drop || fifo_drop) m_ovf = 1'b1;
            else if (evt_if.ovf_clr) m_ovf = 1'b0;
        end
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk_sys) begin : compare
        logic [9:0] head;
        if (model_live) begin
            head = (mq.size() > 0) ? mq[0] : 10'h0;
            cmp("m_valid",   {31'b0, evt_if.ev_valid},   {31'b0, mq.size() > 0});
            cmp("m_count",   32'(evt_if.ev_count),       32'(mq.size()));
            cmp("m_ovf",     {31'b0, evt_if.ev_ovf},     {31'b0, m_ovf});
            cmp("m_code",    {24'b0, evt_if.ev_code},    {24'b0, head[9:2]});
            cmp("m_ext",     {31'b0, evt_if.ev_ext},     {31'b0, head[1]});
            cmp("m_pressed", {31'b0, evt_if.ev_pressed}, {31'b0, head[0]});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic applyStimulus(input logic [63:0] w);
        ps2_key = {~ps2_key[64], w};
    endtask

    task automatic checkOutput(input string name, input logic v, input logic [7:0] code,
                               input logic ext, input logic pr, input int cnt, input logic ovf);
        @(negedge clk_sys);
        cmp({name, "_valid"},   {31'b0, evt_if.ev_valid},   {31'b0, v});
        cmp({name, "_code"},    {24'b0, evt_if.ev_code},    {24'b0, code});
        cmp({name, "_ext"},     {31'b0, evt_if.ev_ext},     {31'b0, ext});
        cmp({name, "_pressed"}, {31'b0, evt_if.ev_pressed}, {31'b0, pr});
        cmp({name, "_count"},   32'(evt_if.ev_count),       32'(cnt));
        cmp({name, "_ovf"},     {31'b0, evt_if.ev_ovf},     {31'b0, ovf});
    endtask

    task automatic drain();
        evt_if.ev_rd = 1'b1;
        tick(DEPTH + 2);
        evt_if.ev_rd = 1'b0;
    endtask

    task automatic clearOvf();
        evt_if.ovf_clr = 1'b1;
        tick(1);
        evt_if.ovf_clr = 1'b0;
    endtask

    function automatic logic [63:0] randWord();
        logic [63:0] w = '0;
        int nb = $urandom_range(1, 8);
        logic [7:0] b;
        for (int i = 0; i < nb; i++) begin
            case ($urandom_range(0, 7))
                0:       b = 8'hE0;
                1:       b = 8'hF0;
                2:       b = 8'hE1;
                3:       b = 8'h00;
                default: b = 8'($urandom_range(1, 255));
            endcase
            w[8*i +: 8] = b;
        end
        return w;
    endfunction

    task automatic randomPhase(input int cycles, input int tgl_pct, input int rd_pct);
        for (int n = 0; n < cycles; n++) begin
            if ($urandom_range(0, 99) < tgl_pct) applyStimulus(randWord());
            evt_if.ev_rd   = ($urandom_range(0, 99) < rd_pct);
            evt_if.ovf_clr = ($urandom_range(0, 99) < 3);
            reset          = (n == cycles / 2);
            tick(1);
        end
        evt_if.ev_rd   = 1'b0;
        evt_if.ovf_clr = 1'b0;
        reset          = 1'b0;
    endtask

    // ---------------- scenario ----------------
    initial begin
        reset          = 1'b1;
        ps2_key        = '0;
        evt_if.ev_rd   = 1'b0;
        evt_if.ovf_clr = 1'b0;
        tick(3);
        reset = 1'b0;
        checkOutput("reset", 0, 8'h00, 0, 0, 0, 0);

        // Make code: nine-edge latency into the empty FIFO, then pop.
        tick(1);
        applyStimulus(64'h1C);
        tick(8);
        checkOutput("make_early", 0, 8'h00, 0, 0, 0, 0);
        tick(1);
        checkOutput("make", 1, 8'h1C, 0, 1, 1, 0);
        tick(1);
        evt_if.ev_rd = 1'b1;
        tick(1);
        evt_if.ev_rd = 1'b0;
        checkOutput("make_pop", 0, 8'h00, 0, 0, 0, 0);

        // Extended break.
        tick(1);
        applyStimulus(64'hE0F075);
        tick(10);
        checkOutput("ext_brk", 1, 8'h75, 1, 0, 1, 0);
        drain();

        // Seventeen events without reads: one is dropped, head stays first.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(64'(8'h10 + i));
            tick(10);
        end
        checkOutput("ovf_full", 1, 8'h10, 0, 1, 16, 1);
        tick(1);
        clearOvf();
        checkOutput("ovf_clr", 1, 8'h10, 0, 1, 16, 0);
        drain();

        // Three toggles on consecutive cycles: third finds pending occupied.
        tick(1);
        applyStimulus(64'h21);
        tick(1);
        applyStimulus(64'h22);
        tick(1);
        applyStimulus(64'h23);
        tick(25);
        checkOutput("burst", 1, 8'h21, 0, 1, 2, 1);
        drain();
        clearOvf();

        // Pause sequence.
        applyStimulus(64'hE11477E1F014F077);
        tick(12);
`ifdef PS2_PAUSE_EN
        checkOutput("pause", 1, 8'h77, 1, 1, 1, 0);
`else
        checkOutput("pause", 0, 8'h00, 0, 0, 0, 0);
`endif
        drain();

        // Reset mid-scan with a queued event, a pending word and bit 64 held high.
        applyStimulus(64'h29);
        tick(10);
        applyStimulus(64'h2A);
        tick(1);
        applyStimulus(64'h2B);
        tick(3);
        reset   = 1'b1;
        ps2_key = {1'b1, 64'h2C};
        tick(3);
        reset = 1'b0;
        checkOutput("rst_release", 0, 8'h00, 0, 0, 0, 0);
        tick(15);
        checkOutput("rst_quiet", 0, 8'h00, 0, 0, 0, 0);

        // Randomized traffic: relaxed, then heavy enough to overflow.
        tick(1);
        randomPhase(1500, 12, 30);
        randomPhase(1200, 45, 5);
        randomPhase(600, 10, 60);
        tick(20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
